// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI frame controller: FSM encoding, default sizing and SPI mode constants.
package spi_frame_pkg;

    localparam int DEF_MAX_BYTES = 8;
    localparam int DEF_CS_HOLD   = 2;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        RESP
    } frame_state_t;

endpackage

// File: rtl/spi_frame_bytesel.sv
// Byte pointer, send-byte mux and receive shift register for spi_frame_ctrl.
// Receive capture exists only when SPI_FRAME_READBACK_EN is defined; otherwise rsp_data is constant 0.
module spi_frame_bytesel
    import spi_frame_pkg::*;
#(
    parameter int MAX_BYTES = DEF_MAX_BYTES,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   advance,
    input  logic                   load_rsp,
    input  logic [LEN_W-1:0]       len,
    input  logic [8*MAX_BYTES-1:0] data,
    input  logic [7:0]             rec_byte,
    output logic [7:0]             next_byte,
    output logic                   more,
    output logic [8*MAX_BYTES-1:0] rsp_data
);

    // ptr is the index of the byte in flight; 0 is the instruction byte.
    logic [LEN_W-1:0] ptr;
    logic [LEN_W-1:0] sel;

    assign more = (ptr < len);
    assign sel  = len - ptr - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (advance && more) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Payload is right-aligned and sent MSB byte first, so byte ptr+1 sits (len-ptr-1) bytes up.
    always_comb begin
        next_byte = '0;
        if (more) begin
            next_byte = 8'(data >> {sel, 3'b000});
        end
    end

`ifdef SPI_FRAME_READBACK_EN
    logic [8*MAX_BYTES-1:0] rx_shift;
    logic [8*MAX_BYTES-1:0] rx_next;
    logic [8*MAX_BYTES-1:0] rsp_q;

    always_comb begin
        rx_next = rx_shift;
        if (advance && (ptr != '0)) begin
            rx_next = {rx_shift[8*MAX_BYTES-9:0], rec_byte};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift <= '0;
            rsp_q    <= '0;
        end else begin
            rx_shift <= clear ? '0 : rx_next;
            if (load_rsp) begin
                rsp_q <= rx_next;
            end
        end
    end

    assign rsp_data = rsp_q;
`else
    logic unused_readback;

    assign unused_readback = ^{load_rsp, rec_byte};
    assign rsp_data        = '0;
`endif

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI frame controller: sends an instruction byte plus up to MAX_BYTES payload bytes through a byte driver.
// Define SPI_FRAME_READBACK_EN to capture received payload bytes into rsp_data.
module spi_frame_ctrl
    import spi_frame_pkg::*;
#(
    parameter int  MAX_BYTES = DEF_MAX_BYTES,
    parameter int  CS_HOLD   = DEF_CS_HOLD,
    localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [7:0]             req_instr,
    input  logic [8*MAX_BYTES-1:0] req_data,
    input  logic [LEN_W-1:0]       req_len,
    input  logic [1:0]             req_mode,
    output logic                   rsp_valid,
    output logic [8*MAX_BYTES-1:0] rsp_data,
    output logic                   busy,
    output logic                   cs_n,
    output logic                   spi_start,
    output logic                   spi_next,
    output logic [7:0]             spi_send_data,
    output logic [1:0]             spi_mode,
    input  logic                   spi_done,
    input  logic [7:0]             spi_rec_data,
    input  logic                   spi_idle
);

    localparam int                HOLD_W    = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((CS_HOLD > 0) ? CS_HOLD - 1 : 0);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_BYTES);

    frame_state_t           state;
    frame_state_t           state_nxt;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [7:0]             instr_q;
    logic [8*MAX_BYTES-1:0] data_q;
    logic [LEN_W-1:0]       len_q;
    logic                   accept;
    logic                   advance;
    logic                   more;
    logic                   load_rsp;
    logic [7:0]             next_byte;

    // Ready is forced low during reset so nothing can be accepted while the block is cleared.
    assign req_ready = rst_n && (state == IDLE) && spi_idle;
    assign accept    = req_valid && req_ready;
    assign advance   = (state == XFER) && spi_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            instr_q  <= '0;
            data_q   <= '0;
            len_q    <= '0;
            spi_mode <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
            if (accept) begin
                instr_q  <= req_instr;
                data_q   <= req_data;
                len_q    <= (req_len > LEN_MAX) ? LEN_MAX : req_len;
                spi_mode <= req_mode;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        load_rsp      = 1'b0;
        cs_n          = 1'b1;
        spi_start     = 1'b0;
        spi_next      = 1'b0;
        spi_send_data = '0;
        rsp_valid     = 1'b0;
        busy          = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                cs_n          = 1'b0;
                spi_start     = 1'b1;
                spi_next      = more;
                spi_send_data = instr_q;
                state_nxt     = XFER;
            end
            XFER: begin
                cs_n          = 1'b0;
                spi_next      = more;
                spi_send_data = next_byte;
                if (spi_done && !more) begin
                    if (CS_HOLD > 0) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = RESP;
                        load_rsp  = 1'b1;
                    end
                end
            end
            HOLD: begin
                cs_n = 1'b0;
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = RESP;
                    load_rsp  = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    spi_frame_bytesel #(
        .MAX_BYTES(MAX_BYTES),
        .LEN_W    (LEN_W)
    ) u_bytesel (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .advance  (advance),
        .load_rsp (load_rsp),
        .len      (len_q),
        .data     (data_q),
        .rec_byte (spi_rec_data),
        .next_byte(next_byte),
        .more     (more),
        .rsp_data (rsp_data)
    );

endmodule
